// File: rtl/rom_streamer_if.sv
// rtl/rom_streamer_if.sv - valid/ready word stream carrying ROM data with a last-word marker
interface rom_streamer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/rom_streamer.sv
// rtl/rom_streamer.sv - walks a synchronous ROM from a base address and streams the words out
module rom_streamer #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int ADDRW = $clog2(DEPTH),
  localparam int LENW  = ADDRW + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDRW-1:0]     start_addr,
  input  logic [LENW-1:0]      len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDRW-1:0]     rom_addr,
  input  logic [WIDTH-1:0]     rom_data,
  rom_streamer_if.master       out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(DEPTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [LENW-1:0]  rem_issue;
  logic [LENW-1:0]  rem_out;
  logic             inflight;
  logic [1:0]       count;
  logic             wr_ptr;
  logic             rd_ptr;
  logic [WIDTH-1:0] buf_mem [2];

  logic             pop;
  logic             issue;
  logic             last_pop;
  logic             accept;
  logic [2:0]       occ;

  assign busy          = (state != IDLE);
  assign out.out_valid = (count != 2'd0);
  assign out.out_data  = buf_mem[rd_ptr];
  assign out.out_last  = out.out_valid && (rem_out == LENW'(1));

  // Credit check counts the word already in flight from the ROM so the buffer never overflows.
  always_comb begin
    pop       = out.out_valid & out.out_ready;
    occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue     = (state == RUN) && (occ < 3'd2);
    last_pop  = pop && (rem_out == LENW'(1));
    accept    = (state == IDLE) && start && (len != '0);
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (issue && (rem_issue == LENW'(1))) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      rem_issue <= '0;
      rem_out   <= '0;
      inflight  <= 1'b0;
      count     <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= ((state == IDLE) && start && (len == '0)) || ((state == DRAIN) && last_pop);
      inflight <= issue;
      count    <= count + {1'b0, inflight} - {1'b0, pop};
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        rem_out <= rem_out - LENW'(1);
      end
      if (accept) begin
        rom_addr  <= start_addr;
        rem_issue <= len;
        rem_out   <= len;
      end else if (issue) begin
        rom_addr  <= (rom_addr == LAST_ADDR) ? '0 : rom_addr + ADDRW'(1);
        rem_issue <= rem_issue - LENW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) buf_mem[wr_ptr] <= rom_data;
  end

endmodule

// File: tb/tb_rom_streamer.sv
// tb/tb_rom_streamer.sv - directed bench for rom_streamer against an identity-filled ROM
module tb_rom_streamer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] start_addr = 8'h00;
  logic [8:0] len = 9'd0;
  logic       busy;
  logic       done;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'h00;

  int checks = 0;
  int failures = 0;

  rom_streamer_if #(.WIDTH(8)) s_if ();

  rom_streamer #(.WIDTH(8), .DEPTH(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .out        (s_if)
  );

  always #5 clk = ~clk;

  // ROM contents memory[i] = i with one cycle of read latency
  always @(posedge clk) rom_data <= rom_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic stream(input logic [7:0] base, input int n, input bit toggle, input int inject);
    int         idx = 0;
    int         dones = 0;
    int         maxc = 0;
    bit         seen_done = 0;
    bit         stall = 0;
    bit         ready_ph = 1;
    logic [7:0] hold_data = 8'h00;
    logic       hold_last = 1'b0;
    logic [7:0] exp_data;
    start = 1'b1;
    start_addr = base;
    len = 9'(n);
    @(posedge clk);
    @(negedge clk);
    for (int cyc = 1; cyc < 200 && !seen_done; cyc++) begin
      if (cyc == inject) begin
        start = 1'b1;
        start_addr = 8'h80;
        len = 9'd2;
      end else begin
        start = 1'b0;
      end
      s_if.out_ready = toggle ? ready_ph : 1'b1;
      ready_ph = ~ready_ph;
      #1;
      if (stall) begin
        check("hold_valid", 32'(s_if.out_valid), 32'd1);
        check("hold_data", 32'(s_if.out_data), 32'(hold_data));
        check("hold_last", 32'(s_if.out_last), 32'(hold_last));
      end
      if (s_if.out_valid && s_if.out_ready) begin
        exp_data = base + 8'(idx);
        check("word_data", 32'(s_if.out_data), 32'(exp_data));
        check("word_last", 32'(s_if.out_last), 32'(idx == n - 1));
        idx++;
      end
      stall = s_if.out_valid && !s_if.out_ready;
      hold_data = s_if.out_data;
      hold_last = s_if.out_last;
      if (int'(dut.count) > maxc) maxc = int'(dut.count);
      if (done) begin
        dones++;
        seen_done = 1;
        check("done_busy", 32'(busy), 32'd0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    s_if.out_ready = 1'b1;
    check("word_count", 32'(idx), 32'(n));
    check("done_seen", 32'(dones), 32'd1);
    check("max_count_le2", 32'(maxc <= 2), 32'd1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("post_done_low", 32'(done), 32'd0);
      check("post_valid_low", 32'(s_if.out_valid), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] exp_w;
    s_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(s_if.out_valid), 32'd0);
    check("rst_last", 32'(s_if.out_last), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    @(negedge clk);

    // Basic 4-word command with exact cycle timing
    start = 1'b1;
    start_addr = 8'h10;
    len = 9'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("c1_busy", 32'(busy), 32'd1);
    check("c1_rom_addr", 32'(rom_addr), 32'h10);
    check("c1_valid", 32'(s_if.out_valid), 32'd0);
    @(negedge clk);
    check("c2_valid", 32'(s_if.out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_w = 8'h10 + 8'(k);
      check("basic_valid", 32'(s_if.out_valid), 32'd1);
      check("basic_data", 32'(s_if.out_data), 32'(exp_w));
      check("basic_last", 32'(s_if.out_last), 32'(k == 3));
      check("basic_done_low", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("c7_done", 32'(done), 32'd1);
    check("c7_busy", 32'(busy), 32'd0);
    check("c7_valid", 32'(s_if.out_valid), 32'd0);
    @(negedge clk);
    check("c8_done", 32'(done), 32'd0);

    // Address wrap
    stream(8'hFE, 4, 1'b0, 0);

    // Backpressure with toggling ready
    stream(8'h10, 8, 1'b1, 0);

    // Zero-length command
    start = 1'b1;
    start_addr = 8'h40;
    len = 9'd0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    check("len0_valid", 32'(s_if.out_valid), 32'd0);
    @(negedge clk);
    check("len0_done_end", 32'(done), 32'd0);
    check("len0_busy2", 32'(busy), 32'd0);
    check("len0_valid2", 32'(s_if.out_valid), 32'd0);

    // Reset while word 2 is pending
    start = 1'b1;
    start_addr = 8'h10;
    len = 9'd8;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    s_if.out_ready = 1'b0;
    check("pre_rst_valid", 32'(s_if.out_valid), 32'd1);
    check("pre_rst_data", 32'(s_if.out_data), 32'h12);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    s_if.out_ready = 1'b1;
    check("mrst_valid", 32'(s_if.out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mrst_quiet_done", 32'(done), 32'd0);
      check("mrst_quiet_valid", 32'(s_if.out_valid), 32'd0);
    end
    stream(8'h20, 2, 1'b0, 0);

    // Start while busy is ignored
    stream(8'h10, 4, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_streamer.md
# rom_streamer

Sequencer that sits directly upstream of the synchronous ROM. On a start command it walks the ROM address from a base address for a programmed number of words. It absorbs the ROM's fixed one-cycle read latency and presents the words as a valid/ready stream with a last-word marker. A 2-entry buffer gives full throughput when the sink is always ready and loses nothing under backpressure.

## Interface
- WIDTH, default 8: ROM word width in bits.
- DEPTH, default 256: ROM depth in words. Any value ≥ 2; need not be a power of two.
- ADDRW, localparam = $clog2(DEPTH): address width.
- LENW, localparam = ADDRW+1: length width, so that DEPTH itself is representable.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  command strobe; sampled only in IDLE.
- start_addr  in  ADDRW  first ROM address; must be < DEPTH.
- len  in  LENW  words to stream, 0..DEPTH.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle completion pulse.
- rom_addr  out  ADDRW  address to the ROM; registered.
- rom_data  in  WIDTH  ROM read data; valid one cycle after rom_addr.
- out_data  out  WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  high with the final word of the command.

## Operation
- States:
  - IDLE: start=1 and len≠0 → RUN. Load addr←start_addr, remaining_issue←len, remaining_out←len.
  - IDLE with start=1 and len=0: stay in IDLE, pulse done next cycle, emit no words.
  - RUN: issue reads. When remaining_issue reaches 0 → DRAIN.
  - DRAIN: wait for buffered words to leave. The handshake of the last word → IDLE, with done=1 on the following cycle.
- start in RUN or DRAIN is ignored; the command registers stay unchanged.
- Issue rule, evaluated each cycle in RUN:
  - issue = (count + inflight − pop) < 2.
  - count = buffer occupancy (0..2); inflight = read issued last cycle (0/1); pop = out_valid & out_ready.
  - On issue, rom_addr advances and remaining_issue decrements.
- Address increment: addr = (addr == DEPTH−1) ? 0 : addr+1. Wrap-around is legal mid-command.
- Capture: when inflight=1, rom_data is written into the buffer that cycle. inflight is a register set by issue.
- Buffer: 2-entry FIFO. out_data comes from the head entry.
  - Push and pop in the same cycle is legal; count is unchanged.
  - The credit rule guarantees no overflow.
- out_last = out_valid & (remaining_out == 1). remaining_out decrements on each pop.
- Every word appears exactly once, in address order.
- While out_valid=1 and out_ready=0, out_data and out_last are held stable.
- rom_addr holds its last value when not issuing. The ROM reads every cycle, but captured data is gated by inflight.

## Timing
- Reset values (rst_n=0 on an edge): state=IDLE, busy=0, done=0, out_valid=0, out_last=0, rom_addr=0, count=0, inflight=0.
- Reset mid-command flushes everything. The command is abandoned and no done pulse is produced.
- Cycle 0: start accepted in IDLE.
- Cycle 1: busy=1 and rom_addr=start_addr (first issue).
- Cycle 2: word 0 captured at the end of the cycle.
- Cycle 3: out_valid=1 with word 0. Start-to-first-valid latency is 3 cycles.
- With out_ready held at 1: one word per cycle, no bubbles. A command of N words finishes its last handshake in cycle N+2.
- done: pulses in the cycle after the last handshake. busy falls in that same cycle.
- len=0: done=1 in cycle 1; busy stays 0.
- A new start is accepted in the done cycle itself.

## Test plan
- ROM filled with memory[i]=i (DEPTH=256). start_addr=0x10, len=4, out_ready=1 → out_data 0x10,0x11,0x12,0x13 in cycles 3–6; out_last only in cycle 6; done in cycle 7.
- Wrap: start_addr=0xFE, len=4 → 0xFE,0xFF,0x00,0x01; out_last on 0x01.
- Backpressure: len=8, out_ready toggling 1,0,1,0… → 0x10..0x17 each exactly once. out_data stable whenever valid&!ready. count never exceeds 2.
- len=0 → done=1 in cycle 1, out_valid never high, busy never high.
- Reset: rst_n=0 for one edge while word 2 is pending → next cycle out_valid=0, busy=0, done=0. A following start_addr=0x20, len=2 yields 0x20,0x21 normally.
- A start pulse with start_addr=0x80 during an active len=4 command → ignored. The original 4 words stream unchanged, followed by a single done pulse.
